// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the core's load/store port. It accepts one request,
// waits a fixed number of cycles, does a byte-masked write or a full-word read, then pulses valid.
module dmem_wait_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request,
    input  logic              we_re,
    input  logic [3:0]        mask,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic              valid,
    output logic [31:0]       data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        counter;
    logic              cap_we;
    logic [3:0]        cap_mask;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_data;
    logic              accept;
    logic              access;

    logic [31:0] mem [2**ADDR_W];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    state_next = WAIT;
                    accept     = 1'b1;
                end
            end
            WAIT: begin
                if (counter == 4'd0) begin
                    state_next = RESP;
                    access     = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched at acceptance, so the initiator may change them freely afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= 4'd0;
            valid    <= 1'b0;
            data_out <= 32'd0;
            cap_we   <= 1'b0;
            cap_mask <= 4'd0;
            cap_addr <= '0;
            cap_data <= 32'd0;
        end else begin
            state <= state_next;
            valid <= access;
            if (accept) begin
                counter  <= 4'(LATENCY);
                cap_we   <= we_re;
                cap_mask <= mask;
                cap_addr <= address;
                cap_data <= data_in;
            end else if (state == WAIT && counter != 4'd0) begin
                counter <= counter - 4'd1;
            end
            if (access && !cap_we) begin
                data_out <= mem[cap_addr];
            end
        end
    end

    // The storage array has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (access && cap_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_mask[i]) begin
                    mem[cap_addr][8*i +: 8] <= cap_data[8*i +: 8];
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench for dmem_wait_responder. One instance uses LATENCY=2 and one uses LATENCY=0.
// Both are checked against a word-array reference model.
module tb_dmem_wait_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req2 = 1'b0, we2 = 1'b0, valid2, busy2;
    logic [3:0]  mask2 = 4'd0;
    logic [7:0]  addr2 = 8'd0;
    logic [31:0] din2 = 32'd0, dout2;

    logic        req0 = 1'b0, we0 = 1'b0, valid0, busy0;
    logic [3:0]  mask0 = 4'd0;
    logic [7:0]  addr0 = 8'd0;
    logic [31:0] din0 = 32'd0, dout0;

    logic [31:0] model2 [256];
    logic [31:0] model0 [256];
    logic [31:0] last_rd2 = 32'd0;
    logic [31:0] last_rd0 = 32'd0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dmem_wait_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .request(req2), .we_re(we2), .mask(mask2),
        .address(addr2), .data_in(din2), .valid(valid2), .data_out(dout2), .busy(busy2)
    );

    dmem_wait_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .request(req0), .we_re(we0), .mask(mask0),
        .address(addr0), .data_in(din0), .valid(valid0), .data_out(dout0), .busy(busy0)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        else passes++;
    endtask

    task automatic drive_in(input bit sel0, input bit r, input bit we, input logic [3:0] m,
                            input logic [7:0] a, input logic [31:0] d);
        if (sel0) begin
            req0 = r; we0 = we; mask0 = m; addr0 = a; din0 = d;
        end else begin
            req2 = r; we2 = we; mask2 = m; addr2 = a; din2 = d;
        end
    endtask

    // Runs one complete transaction. Expected latency, busy time and data come from the model.
    // With churn set, the request fields are overwritten during the wait states.
    task automatic do_txn(input bit sel0, input bit we, input logic [3:0] m, input logic [7:0] a,
                          input logic [31:0] d, input bit churn, input string name);
        int          lat_exp;
        int          busy_cnt;
        int          seen_at;
        bit          got;
        logic [31:0] exp_rd;
        logic        v;
        logic        b;
        logic [31:0] q;
        lat_exp = sel0 ? 0 : 2;
        if (we) begin
            if (sel0) model0[a] = merge(model0[a], d, m);
            else      model2[a] = merge(model2[a], d, m);
            exp_rd = sel0 ? last_rd0 : last_rd2;
        end else begin
            exp_rd = sel0 ? model0[a] : model2[a];
            if (sel0) last_rd0 = exp_rd;
            else      last_rd2 = exp_rd;
        end
        @(negedge clk);
        drive_in(sel0, 1'b1, we, m, a, d);
        got = 1'b0;
        busy_cnt = 0;
        seen_at = 0;
        q = 32'd0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            v = sel0 ? valid0 : valid2;
            b = sel0 ? busy0 : busy2;
            q = sel0 ? dout0 : dout2;
            if (b === 1'b1) busy_cnt++;
            if (v === 1'b1) begin
                got = 1'b1;
                seen_at = cyc - 1;
            end else if (churn) begin
                drive_in(sel0, 1'b1, 1'b1, 4'hF, 8'h04, 32'hFFFFFFFF);
            end
        end
        drive_in(sel0, 1'b0, 1'b0, 4'h0, 8'h00, 32'd0);
        if (!got) begin
            checks++;
            $display("[TB] FAIL %s timeout: valid never seen within 40 cycles", name);
            return;
        end
        check({name, " latency"}, 32'(seen_at), 32'(lat_exp + 1));
        check({name, " data_out at valid"}, q, exp_rd);
        @(negedge clk);
        check({name, " valid one cycle"}, {31'd0, sel0 ? valid0 : valid2}, 32'd0);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(lat_exp + 2));
        check({name, " busy after"}, {31'd0, sel0 ? busy0 : busy2}, 32'd0);
        check({name, " data_out held"}, sel0 ? dout0 : dout2, exp_rd);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check("reset valid2", {31'd0, valid2}, 32'd0);
        check("reset busy2", {31'd0, busy2}, 32'd0);
        check("reset data_out2", dout2, 32'd0);
        check("reset valid0", {31'd0, valid0}, 32'd0);
        check("reset busy0", {31'd0, busy0}, 32'd0);
        check("reset data_out0", dout0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        do_txn(1'b0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, "full write");
        do_txn(1'b0, 1'b0, 4'h0, 8'h10, 32'd0, 1'b0, "full read");
        check("full read constant", dout2, 32'hDEADBEEF);
    endtask

    task automatic test_masked();
        do_txn(1'b0, 1'b1, 4'hF, 8'h05, 32'h11223344, 1'b0, "preload 05");
        do_txn(1'b0, 1'b1, 4'b0101, 8'h05, 32'hAABBCCDD, 1'b0, "masked write");
        do_txn(1'b0, 1'b0, 4'hF, 8'h05, 32'd0, 1'b0, "masked read");
        check("masked constant", dout2, 32'h11BB33DD);
        do_txn(1'b0, 1'b1, 4'b0000, 8'h05, 32'hFFFFFFFF, 1'b0, "mask0 write");
        do_txn(1'b0, 1'b0, 4'hF, 8'h05, 32'd0, 1'b0, "mask0 read");
        check("mask0 constant", dout2, 32'h11BB33DD);
    endtask

    task automatic test_latency0();
        do_txn(1'b1, 1'b1, 4'hF, 8'hFF, 32'h0000CAFE, 1'b0, "lat0 write");
        do_txn(1'b1, 1'b0, 4'h0, 8'hFF, 32'd0, 1'b0, "lat0 read");
        check("lat0 constant", dout0, 32'h0000CAFE);
    endtask

    task automatic test_churn();
        do_txn(1'b0, 1'b1, 4'hF, 8'h03, 32'h12345678, 1'b0, "churn preload 03");
        do_txn(1'b0, 1'b1, 4'hF, 8'h04, 32'hA5A5A5A5, 1'b0, "churn preload 04");
        do_txn(1'b0, 1'b0, 4'h0, 8'h03, 32'd0, 1'b1, "churn read 03");
        do_txn(1'b0, 1'b0, 4'h0, 8'h04, 32'd0, 1'b0, "churn read 04");
        check("churn 04 untouched", dout2, 32'hA5A5A5A5);
    endtask

    // Two reads with request held high the whole time, counted over a fixed window.
    task automatic test_back_to_back();
        int          pulses;
        int          t1;
        int          t2;
        int          idle_between;
        logic [31:0] d1;
        logic [31:0] d2;
        pulses = 0; t1 = 0; t2 = 0; idle_between = 0; d1 = 32'd0; d2 = 32'd0;
        @(negedge clk);
        drive_in(1'b0, 1'b1, 1'b0, 4'h0, 8'h10, 32'd0);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            if (pulses == 1 && busy2 === 1'b0) idle_between++;
            if (valid2 === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    t1 = cyc; d1 = dout2;
                    drive_in(1'b0, 1'b1, 1'b0, 4'h0, 8'h03, 32'd0);
                end else if (pulses == 2) begin
                    t2 = cyc; d2 = dout2;
                    drive_in(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'd0);
                end
            end
        end
        last_rd2 = model2[8'h03];
        check("b2b pulse count", 32'(pulses), 32'd2);
        check("b2b spacing", 32'(t2 - t1), 32'd5);
        check("b2b busy low cycles", 32'(idle_between), 32'd1);
        check("b2b first data", d1, model2[8'h10]);
        check("b2b second data", d2, model2[8'h03]);
    endtask

    task automatic test_reset_mid();
        do_txn(1'b0, 1'b1, 4'hF, 8'h20, 32'h00000000, 1'b0, "rst preload 20");
        do_txn(1'b0, 1'b0, 4'h0, 8'h10, 32'd0, 1'b0, "rst nonzero read");
        @(negedge clk);
        drive_in(1'b0, 1'b1, 1'b1, 4'hF, 8'h20, 32'h55555555);
        @(negedge clk);
        drive_in(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst wait valid", {31'd0, valid2}, 32'd0);
        check("rst wait data_out", dout2, 32'd0);
        check("rst wait busy", {31'd0, busy2}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd2 = 32'd0;
        last_rd0 = 32'd0;
        do_txn(1'b0, 1'b0, 4'h0, 8'h20, 32'd0, 1'b0, "rst read 20");
        @(negedge clk);
        drive_in(1'b0, 1'b1, 1'b0, 4'h0, 8'h10, 32'd0);
        repeat (4) @(negedge clk);
        drive_in(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'd0);
        check("rst resp valid before", {31'd0, valid2}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst resp valid", {31'd0, valid2}, 32'd0);
        check("rst resp data_out", dout2, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd2 = 32'd0;
        last_rd0 = 32'd0;
        do_txn(1'b0, 1'b0, 4'h0, 8'h10, 32'd0, 1'b0, "rst memory kept");
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            do_txn(1'b0, 1'b1, 4'hF, 8'(8'hF8 + i), $urandom(), 1'b0, "rand preload");
        end
        for (int i = 0; i < 16; i++) begin
            r = $urandom();
            d = $urandom();
            do_txn(1'b0, r[0], r[7:4], 8'(8'hF8 + r[10:8]), d, 1'b0, "rand op");
        end
        for (int i = 0; i < 6; i++) begin
            r = $urandom();
            d = $urandom();
            do_txn(1'b1, r[0], r[7:4], 8'hFF, d, 1'b0, "rand lat0 op");
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_masked();
        test_latency0();
        test_churn();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Data-memory responder for the core's load/store port; the target end of the request / we_re / mask / valid handshake.
- Accepts one request at a time and holds it for a programmable number of wait states.
- Performs a byte-masked write or a full-word read on an internal word array, then pulses valid for one cycle.
- Lets the core's stall logic (load && !valid) be exercised against a memory with real latency.

Parameters:
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, wait states between acceptance and access; legal range 0..15; 4-bit counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  1  initiator asserts to start an access; held high until valid is seen.
- we_re  input  1  1 = write (store), 0 = read (load); sampled at acceptance.
- mask  input  4  byte enables for writes; bit i enables data_in[8i+7:8i]; ignored on reads.
- address  input  ADDR_W  word address, sampled at acceptance.
- data_in  input  32  store data, sampled at acceptance.
- valid  output  1  registered; one-cycle pulse marking completion of the accepted access.
- data_out  output  32  registered read data; holds its value until the next read completes.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, valid = 0, data_out = 0, busy = 0, counter = 0.
  - Array contents are not reset and are preserved across reset.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - RESP: one-cycle valid pulse.
- IDLE:
  - At an edge with request = 1, capture we_re, mask, address and data_in.
  - Load counter with LATENCY and go to WAIT.
  - request = 0: remain in IDLE.
- WAIT:
  - Counter != 0: decrement at each edge.
  - Counter == 0: at the next edge perform the access, set valid = 1, go to RESP.
- Access:
  - Write: for each i with captured mask[i] = 1, array[addr] byte i <= data byte i; other bytes unchanged; data_out unchanged.
  - Read: data_out <= array[addr] (full word, mask ignored).
- RESP:
  - valid = 1 for exactly this cycle.
  - At the next edge, valid <= 0 and state <= IDLE, regardless of request.
- Latency:
  - Accepting edge = E0; valid is high in the cycle after edge E(LATENCY+1).
  - LATENCY = 0: valid high the cycle after E1.
  - LATENCY = 2: valid high after E3.
- Handshake rules:
  - request, we_re, mask, address and data_in changing during WAIT/RESP have no effect.
  - Captured values are used.
  - Exactly one access and one valid pulse per acceptance.
- Back-to-back:
  - request still high in the IDLE cycle after RESP is a new transaction, accepted at that edge.
  - Minimum spacing between valid pulses is LATENCY+3 cycles.
  - The initiator must drop request after seeing valid if it has no further access.
- Boundary cases:
  - Write with mask = 4'b0000: no bytes modified; valid still pulses.
  - Address 2**ADDR_W-1 is legal; no wrap or out-of-range case exists.
  - Read immediately after write to the same address returns the merged written word.
- Reset mid-operation (WAIT or RESP):
  - Transaction aborted; no array write occurs if reset precedes the access edge.
  - valid drops immediately; the next request after reset release starts fresh in IDLE.
- busy equals (state != IDLE), combinationally from the state register.

Test Plan:
- Full-word write then read, LATENCY = 2:
  - Write 0xDEADBEEF, mask 1111, address 0x10 -> valid high exactly 3 cycles after the accept edge, for 1 cycle.
  - Read of 0x10 -> data_out = 0xDEADBEEF, held after valid drops.
- Masked write:
  - Preload 0x11223344 at address 0x05.
  - Write 0xAABBCCDD with mask 0101 -> read returns 0x11BB33DD.
  - Write with mask 0000 -> word unchanged, valid still pulses.
- LATENCY = 0 build:
  - Read address 0xFF after writing 0x0000CAFE -> valid in the cycle after the second edge.
  - data_out = 0x0000CAFE; busy high for exactly 2 cycles.
- Input churn during WAIT:
  - Accept a read of 0x03 (holding 0x12345678).
  - Then drive address = 0x04, we_re = 1 and data_in = 0xFFFFFFFF during WAIT -> data_out = 0x12345678.
  - Address 0x04 is not modified.
- Back-to-back with request held high:
  - Two reads -> exactly two valid pulses separated by LATENCY+3 cycles.
  - busy low for exactly one cycle between them.
- Reset mid-operation:
  - Assert rst during WAIT of a write of 0x55555555 to 0x20 (old value 0x0) -> valid = 0 and data_out = 0 immediately.
  - Later read of 0x20 returns 0x00000000.
